// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared constants and types for the direct-mapped instruction cache.
//   - Default geometry (lines, words per line, address/data width).
//   - Derived index/offset/tag field widths for the default geometry.
//   - FSM state encoding used by icache_ctrl.
// -----------------------------------------------------------------------------
package icache_pkg;

   localparam int IC_ADDR_W     = 32;
   localparam int IC_DATA_W     = 32;
   localparam int IC_LINES      = 64;
   localparam int IC_LINE_WORDS = 4;

   // Address layout: [tag | index | offset | 2'b00]
   localparam int IC_OFF_W = $clog2(IC_LINE_WORDS);
   localparam int IC_IDX_W = $clog2(IC_LINES);
   localparam int IC_TAG_W = IC_ADDR_W - IC_IDX_W - IC_OFF_W - 2;

   typedef enum logic [1:0] {
      IC_IDLE    = 2'd0,
      IC_REFILL  = 2'd1,
      IC_RESPOND = 2'd2
   } ic_state_t;

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Valid/tag/data storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (invalidates all)
//   rd_index           combinational read index
//   rd_valid/rd_tag    valid bit and tag of the indexed line
//   rd_line            all words of the indexed line
//   wr_en/wr_index/wr_offset/wr_data   synchronous single-word write
//   inv_en/inv_index   clear one valid bit
//   inst_en/inst_index/inst_tag        install tag and set valid
// -----------------------------------------------------------------------------
module icache_array
   import icache_pkg::*;
#(
   parameter int IDX_W = IC_IDX_W,
   parameter int OFF_W = IC_OFF_W,
   parameter int TAG_W = IC_TAG_W
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [IDX_W-1:0]                       rd_index,
   output logic                                   rd_valid,
   output logic [TAG_W-1:0]                       rd_tag,
   output logic [(1<<OFF_W)-1:0][IC_DATA_W-1:0]   rd_line,
   input  logic                                   wr_en,
   input  logic [IDX_W-1:0]                       wr_index,
   input  logic [OFF_W-1:0]                       wr_offset,
   input  logic [IC_DATA_W-1:0]                   wr_data,
   input  logic                                   inv_en,
   input  logic [IDX_W-1:0]                       inv_index,
   input  logic                                   inst_en,
   input  logic [IDX_W-1:0]                       inst_index,
   input  logic [TAG_W-1:0]                       inst_tag
);

   localparam int NLINES = 1 << IDX_W;
   localparam int NWORDS = 1 << OFF_W;

   logic [NLINES-1:0]    valid;
   logic [TAG_W-1:0]     tags  [NLINES];
   logic [IC_DATA_W-1:0] words [NLINES*NWORDS];

   // Only the valid bits need reset; tags and data are qualified by them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
      end else begin
         if (inv_en)  valid[inv_index]  <= 1'b0;
         if (inst_en) valid[inst_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (inst_en) tags[inst_index] <= inst_tag;
      if (wr_en)   words[{wr_index, wr_offset}] <= wr_data;
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];

   for (genvar w = 0; w < NWORDS; w++) begin : g_rd
      assign rd_line[w] = words[{rd_index, OFF_W'(w)}];
   end

endmodule

// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl
// Direct-mapped instruction cache and line-refill controller sitting between
// the instruction fetcher and the memory controller's fetch port.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rdy             global ready; everything frozen while low
//   rollback        ROB flush; aborts any request/refill
//   if_en, if_pc    fetch request (held until if_done or rollback)
//   if_done,if_data one-cycle response pulse and instruction word
//   mc_en, mc_pc    word request to memory controller (held until mc_done)
//   mc_done,mc_data memory controller word return
// Build option:
//   ICACHE_EARLY_RESTART_EN  critical-word-first refill with early if_done.
// -----------------------------------------------------------------------------
module icache_ctrl
   import icache_pkg::*;
#(
   parameter int LINES      = IC_LINES,
   parameter int LINE_WORDS = IC_LINE_WORDS,
   parameter int ADDR_W     = IC_ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 rollback,
   input  logic                 if_en,
   input  logic [ADDR_W-1:0]    if_pc,
   output logic                 if_done,
   output logic [IC_DATA_W-1:0] if_data,
   output logic                 mc_en,
   output logic [ADDR_W-1:0]    mc_pc,
   input  logic                 mc_done,
   input  logic [IC_DATA_W-1:0] mc_data
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

   function automatic logic [OFF_W-1:0] off_of(input logic [ADDR_W-1:0] pc);
      return pc[OFF_W+1:2];
   endfunction

   function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] pc);
      return pc[IDX_W+OFF_W+1:OFF_W+2];
   endfunction

   function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] pc);
      return pc[ADDR_W-1:IDX_W+OFF_W+2];
   endfunction

   ic_state_t         state;
   logic [ADDR_W-1:0] req_pc;
   logic [OFF_W-1:0]  cnt;
   logic              req_live;   // requester still waiting for this line

   logic [IDX_W-1:0]                          arr_index;
   logic                                      arr_valid;
   logic [TAG_W-1:0]                          arr_tag;
   logic [LINE_WORDS-1:0][IC_DATA_W-1:0]      arr_line;

   logic              hit;
   logic              accept;
   logic              take;
   logic              last;
   logic [OFF_W-1:0]  cnt_nxt;
   logic [OFF_W-1:0]  start_off;
   logic [OFF_W-1:0]  miss_off;

   // In IDLE the lookup uses the live fetch address; otherwise the captured one.
   assign arr_index = (state == IC_IDLE) ? idx_of(if_pc) : idx_of(req_pc);
   assign hit       = arr_valid && (arr_tag == tag_of(if_pc));

`ifdef ICACHE_EARLY_RESTART_EN
   // Refill begins at the requested word and wraps back to it.
   assign start_off = off_of(req_pc);
   assign miss_off  = off_of(if_pc);
`else
   assign start_off = '0;
   assign miss_off  = '0;
`endif

   assign cnt_nxt = cnt + OFF_W'(1);
   assign last    = (cnt_nxt == start_off);

   assign accept = rdy && !rollback && (state == IC_IDLE) && if_en && !if_done;
   assign take   = rdy && !rollback && (state == IC_REFILL) && mc_en && mc_done;

   icache_array #(
      .IDX_W (IDX_W),
      .OFF_W (OFF_W),
      .TAG_W (TAG_W)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .rd_index   (arr_index),
      .rd_valid   (arr_valid),
      .rd_tag     (arr_tag),
      .rd_line    (arr_line),
      .wr_en      (take),
      .wr_index   (idx_of(req_pc)),
      .wr_offset  (cnt),
      .wr_data    (mc_data),
      .inv_en     (accept && !hit),
      .inv_index  (idx_of(if_pc)),
      .inst_en    (take && last),
      .inst_index (idx_of(req_pc)),
      .inst_tag   (tag_of(req_pc))
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IC_IDLE;
         req_pc   <= '0;
         cnt      <= '0;
         req_live <= 1'b0;
         mc_en    <= 1'b0;
         mc_pc    <= '0;
         if_done  <= 1'b0;
         if_data  <= '0;
      end else if (rdy) begin
         if_done <= 1'b0;
         if (rollback) begin
            // Line being refilled was invalidated at the miss and stays so.
            state    <= IC_IDLE;
            mc_en    <= 1'b0;
            cnt      <= '0;
            req_live <= 1'b0;
         end else begin
            case (state)
               IC_IDLE: begin
                  if (if_en && !if_done) begin
                     req_pc <= if_pc;
                     if (hit) begin
                        if_done <= 1'b1;
                        if_data <= arr_line[off_of(if_pc)];
                     end else begin
                        mc_en    <= 1'b1;
                        mc_pc    <= {if_pc[ADDR_W-1:OFF_W+2], miss_off, 2'b00};
                        cnt      <= miss_off;
                        req_live <= 1'b1;
                        state    <= IC_REFILL;
                     end
                  end
               end

               IC_REFILL: begin
                  if (!if_en) req_live <= 1'b0;
                  if (mc_en && mc_done) begin
                     cnt   <= cnt_nxt;
                     mc_pc <= {mc_pc[ADDR_W-1:OFF_W+2], cnt_nxt, 2'b00};
`ifdef ICACHE_EARLY_RESTART_EN
                     // First returned word is the critical one.
                     if (cnt == start_off && req_live && if_en) begin
                        if_done <= 1'b1;
                        if_data <= mc_data;
                     end
                     if (cnt == start_off) req_live <= 1'b0;
`endif
                     if (last) begin
                        mc_en <= 1'b0;
                        cnt   <= '0;
`ifdef ICACHE_EARLY_RESTART_EN
                        state <= IC_IDLE;
`else
                        state <= (req_live && if_en) ? IC_RESPOND : IC_IDLE;
`endif
                     end
                  end
               end

               IC_RESPOND: begin
                  if_done  <= 1'b1;
                  if_data  <= arr_line[off_of(req_pc)];
                  req_live <= 1'b0;
                  state    <= IC_IDLE;
               end

               default: state <= IC_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        rollback;
   logic        if_en;
   logic [31:0] if_pc;
   logic        if_done;
   logic [31:0] if_data;
   logic        mc_en;
   logic [31:0] mc_pc;
   logic        mc_done;
   logic [31:0] mc_data;

   int checks;
   int errors;

   icache_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .rollback (rollback),
      .if_en    (if_en),
      .if_pc    (if_pc),
      .if_done  (if_done),
      .if_data  (if_data),
      .mc_en    (mc_en),
      .mc_pc    (mc_pc),
      .mc_done  (mc_done),
      .mc_data  (mc_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Memory contents: first line holds 0x11..0x44, elsewhere 0xA0000000|addr.
   function automatic logic [31:0] memv(input logic [31:0] a);
      if (a < 32'h10) return ((a >> 2) + 32'd1) * 32'h11;
      return 32'hA000_0000 | a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [31:0] d);
      mc_done = 1'b1;
      mc_data = d;
      tick();
      mc_done = 1'b0;
      mc_data = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL reset_if_done: got %b want 0", if_done); end
      checks++; if (if_data !== 32'h0) begin errors++; $display("FAIL reset_if_data: got %h want 0", if_data); end
      checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL reset_mc_en: got %b want 0", mc_en); end
      checks++; if (mc_pc !== 32'h0) begin errors++; $display("FAIL reset_mc_pc: got %h want 0", mc_pc); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_cold_miss();
      if_pc = 32'h0; if_en = 1'b1;
      tick();
      checks++; if (mc_en !== 1'b1) begin errors++; $display("FAIL cold_mc_en: got %b want 1", mc_en); end
      checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL cold_no_done: got %b want 0", if_done); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (mc_pc !== 32'(i*4)) begin errors++; $display("FAIL cold_mc_pc%0d: got %h want %h", i, mc_pc, 32'(i*4)); end
         pulse(memv(32'(i*4)));
      end
      checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL cold_mc_en_off: got %b want 0", mc_en); end
      checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL cold_early_done: got %b want 0", if_done); end
      tick();
      checks++; if (if_done !== 1'b1) begin errors++; $display("FAIL cold_done: got %b want 1", if_done); end
      checks++; if (if_data !== 32'h11) begin errors++; $display("FAIL cold_data: got %h want 00000011", if_data); end
      if_en = 1'b0;
      tick();
      checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL cold_pulse_len: got %b want 0", if_done); end
      if_pc = 32'h8; if_en = 1'b1;
      tick();
      checks++; if (if_done !== 1'b1) begin errors++; $display("FAIL hit_done: got %b want 1", if_done); end
      checks++; if (if_data !== 32'h33) begin errors++; $display("FAIL hit_data: got %h want 00000033", if_data); end
      checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL hit_mc_en: got %b want 0", mc_en); end
      if_en = 1'b0;
      tick();
   endtask

   task automatic test_eviction();
      if_pc = 32'h400; if_en = 1'b1;
      tick();
      checks++; if (mc_en !== 1'b1) begin errors++; $display("FAIL evict_miss: got %b want 1", mc_en); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (mc_pc !== 32'h400 + 32'(i*4)) begin errors++; $display("FAIL evict_pc%0d: got %h want %h", i, mc_pc, 32'h400 + 32'(i*4)); end
         pulse(memv(32'h400 + 32'(i*4)));
      end
      tick();
      checks++; if (if_done !== 1'b1 || if_data !== 32'hA000_0400) begin errors++; $display("FAIL evict_data: got %b/%h want 1/a0000400", if_done, if_data); end
      if_en = 1'b0;
      tick();
      if_pc = 32'h0; if_en = 1'b1;
      tick();
      checks++; if (if_done !== 1'b0 || mc_en !== 1'b1 || mc_pc !== 32'h0) begin errors++; $display("FAIL evict_remiss: got done=%b mc_en=%b mc_pc=%h want 0/1/0", if_done, mc_en, mc_pc); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (mc_pc !== 32'(i*4)) begin errors++; $display("FAIL evict_refill_pc%0d: got %h want %h", i, mc_pc, 32'(i*4)); end
         pulse(memv(32'(i*4)));
      end
      tick();
      checks++; if (if_done !== 1'b1 || if_data !== 32'h11) begin errors++; $display("FAIL evict_refill_data: got %b/%h want 1/00000011", if_done, if_data); end
      if_en = 1'b0;
      tick();
   endtask

   task automatic test_rollback();
      if_pc = 32'h40; if_en = 1'b1;
      tick();
      pulse(memv(32'h40));
      pulse(memv(32'h44));
      checks++; if (mc_pc !== 32'h48 || mc_en !== 1'b1) begin errors++; $display("FAIL rb_pre: got mc_pc=%h mc_en=%b want 48/1", mc_pc, mc_en); end
      // Rollback coincides with a word return; rollback must win.
      rollback = 1'b1; mc_done = 1'b1; mc_data = memv(32'h48);
      tick();
      rollback = 1'b0; mc_done = 1'b0; if_en = 1'b0;
      checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL rb_mc_en: got %b want 0", mc_en); end
      checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL rb_done: got %b want 0", if_done); end
      tick();
      checks++; if (if_done !== 1'b0 || mc_en !== 1'b0) begin errors++; $display("FAIL rb_quiet: got done=%b mc_en=%b want 0/0", if_done, mc_en); end
      if_pc = 32'h44; if_en = 1'b1;
      tick();
      checks++; if (mc_en !== 1'b1 || mc_pc !== 32'h40) begin errors++; $display("FAIL rb_remiss: got mc_en=%b mc_pc=%h want 1/40", mc_en, mc_pc); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (mc_pc !== 32'h40 + 32'(i*4)) begin errors++; $display("FAIL rb_pc%0d: got %h want %h", i, mc_pc, 32'h40 + 32'(i*4)); end
         pulse(memv(32'h40 + 32'(i*4)));
      end
      tick();
      checks++; if (if_done !== 1'b1 || if_data !== 32'hA000_0044) begin errors++; $display("FAIL rb_data: got %b/%h want 1/a0000044", if_done, if_data); end
      if_en = 1'b0;
      tick();
   endtask

   task automatic test_rdy_stall();
      if_pc = 32'h80; if_en = 1'b1;
      tick();
      pulse(memv(32'h80));
      rdy = 1'b0; mc_done = 1'b1; mc_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (mc_pc !== 32'h84 || mc_en !== 1'b1 || if_done !== 1'b0) begin errors++; $display("FAIL stall%0d: got mc_pc=%h mc_en=%b done=%b want 84/1/0", i, mc_pc, mc_en, if_done); end
      end
      rdy = 1'b1; mc_done = 1'b0; mc_data = 32'h0;
      for (int i = 1; i < 4; i++) begin
         checks++; if (mc_pc !== 32'h80 + 32'(i*4)) begin errors++; $display("FAIL stall_pc%0d: got %h want %h", i, mc_pc, 32'h80 + 32'(i*4)); end
         pulse(memv(32'h80 + 32'(i*4)));
      end
      tick();
      checks++; if (if_done !== 1'b1 || if_data !== 32'hA000_0080) begin errors++; $display("FAIL stall_data: got %b/%h want 1/a0000080", if_done, if_data); end
      if_en = 1'b0;
      tick();
   endtask

   task automatic test_drop();
      if_pc = 32'hC0; if_en = 1'b1;
      tick();
      pulse(memv(32'hC0));
      if_en = 1'b0;
      for (int i = 1; i < 4; i++) begin
         checks++; if (mc_pc !== 32'hC0 + 32'(i*4)) begin errors++; $display("FAIL drop_pc%0d: got %h want %h", i, mc_pc, 32'hC0 + 32'(i*4)); end
         pulse(memv(32'hC0 + 32'(i*4)));
      end
      checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL drop_mc_en: got %b want 0", mc_en); end
      tick();
      checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL drop_done1: got %b want 0", if_done); end
      tick();
      checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL drop_done2: got %b want 0", if_done); end
      if_pc = 32'hC8; if_en = 1'b1;
      tick();
      checks++; if (if_done !== 1'b1 || if_data !== 32'hA000_00C8 || mc_en !== 1'b0) begin errors++; $display("FAIL drop_hit: got %b/%h mc_en=%b want 1/a00000c8/0", if_done, if_data, mc_en); end
      if_en = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      if_pc = 32'h100; if_en = 1'b1;
      tick();
      pulse(memv(32'h100));
      pulse(memv(32'h104));
      rst = 1'b1;
      #1;
      checks++; if (mc_en !== 1'b0 || mc_pc !== 32'h0 || if_done !== 1'b0) begin errors++; $display("FAIL rstmid: got mc_en=%b mc_pc=%h done=%b want 0/0/0", mc_en, mc_pc, if_done); end
      if_en = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      // Line 0 was valid before reset; it must now miss.
      if_pc = 32'h8; if_en = 1'b1;
      tick();
      checks++; if (mc_en !== 1'b1 || mc_pc !== 32'h0 || if_done !== 1'b0) begin errors++; $display("FAIL rstmid_inval: got mc_en=%b mc_pc=%h done=%b want 1/0/0", mc_en, mc_pc, if_done); end
      for (int i = 0; i < 4; i++) pulse(memv(32'(i*4)));
      tick();
      checks++; if (if_done !== 1'b1 || if_data !== 32'h33) begin errors++; $display("FAIL rstmid_data: got %b/%h want 1/00000033", if_done, if_data); end
      if_en = 1'b0;
      tick();
   endtask

   task automatic test_early_restart();
      if_pc = 32'h8; if_en = 1'b1;
      tick();
      checks++; if (mc_en !== 1'b1 || mc_pc !== 32'h8) begin errors++; $display("FAIL er_start: got mc_en=%b mc_pc=%h want 1/8", mc_en, mc_pc); end
      pulse(32'h33);
      checks++; if (if_done !== 1'b1 || if_data !== 32'h33) begin errors++; $display("FAIL er_crit: got %b/%h want 1/00000033", if_done, if_data); end
      checks++; if (mc_pc !== 32'hC) begin errors++; $display("FAIL er_pc1: got %h want c", mc_pc); end
      if_pc = 32'hC;
      pulse(32'h44);
      checks++; if (if_done !== 1'b0 || mc_pc !== 32'h0) begin errors++; $display("FAIL er_pc2: got done=%b mc_pc=%h want 0/0", if_done, mc_pc); end
      pulse(32'h11);
      checks++; if (if_done !== 1'b0 || mc_pc !== 32'h4) begin errors++; $display("FAIL er_pc3: got done=%b mc_pc=%h want 0/4", if_done, mc_pc); end
      pulse(32'h22);
      checks++; if (mc_en !== 1'b0 || if_done !== 1'b0) begin errors++; $display("FAIL er_install: got mc_en=%b done=%b want 0/0", mc_en, if_done); end
      tick();
      checks++; if (if_done !== 1'b1 || if_data !== 32'h44) begin errors++; $display("FAIL er_stall_hit: got %b/%h want 1/00000044", if_done, if_data); end
      if_en = 1'b0;
      tick();
      // Rollback during the tail leaves the line invalid.
      if_pc = 32'h28; if_en = 1'b1;
      tick();
      pulse(memv(32'h28));
      if_en = 1'b0;
      pulse(memv(32'h2C));
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL er_rb: got %b want 0", mc_en); end
      if_pc = 32'h24; if_en = 1'b1;
      tick();
      checks++; if (mc_en !== 1'b1 || mc_pc !== 32'h24) begin errors++; $display("FAIL er_rb_remiss: got mc_en=%b mc_pc=%h want 1/24", mc_en, mc_pc); end
      pulse(memv(32'h24));
      checks++; if (if_done !== 1'b1 || if_data !== 32'hA000_0024) begin errors++; $display("FAIL er_rb_data: got %b/%h want 1/a0000024", if_done, if_data); end
      if_en = 1'b0;
      pulse(memv(32'h28));
      pulse(memv(32'h2C));
      pulse(memv(32'h20));
      tick();
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      rdy      = 1'b1;
      rollback = 1'b0;
      if_en    = 1'b0;
      if_pc    = 32'h0;
      mc_done  = 1'b0;
      mc_data  = 32'h0;
      test_reset();
`ifdef ICACHE_EARLY_RESTART_EN
      test_early_restart();
`else
      test_cold_miss();
      test_eviction();
      test_rollback();
      test_rdy_stall();
      test_drop();
      test_reset_mid();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
Direct-mapped instruction cache and refill controller between the instruction fetcher and the memory controller's instruction-fetch port.
- Serves fetch requests from local tag/data storage on a hit.
- On a miss, sequences whole-line refills as back-to-back word requests over the existing memory-controller fetch handshake.
- Aborts cleanly on ROB rollback.

Parameters:
LINES, 64, number of cache lines (power of two)
LINE_WORDS, 4, 32-bit words per line (power of two, >=2)
ADDR_W, 32, address width

Ports:
clk  in  1  system clock
rst  in  1  reset
rdy  in  1  global ready; all state frozen when low
rollback  in  1  ROB misprediction flush
if_en  in  1  fetch request, held until if_done or rollback
if_pc  in  ADDR_W  fetch address; bits [1:0] ignored
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched instruction
mc_en  out  1  word request to memory controller, held until mc_done
mc_pc  out  ADDR_W  word address requested (bits [1:0]=0)
mc_done  in  1  one-cycle pulse, mc_data valid
mc_data  in  32  returned word

Behaviour:
Clocking and reset:
- One clock, clk.
- Reset rst is asynchronous and active-high.
- On reset: all valid bits 0, state IDLE, if_done=0, if_data=0, mc_en=0, mc_pc=0, word counter 0.

Address fields:
- offset = pc[log2(LINE_WORDS)+1:2]
- index = next log2(LINES) bits
- tag = remaining upper bits

States: IDLE, REFILL, RESPOND.

IDLE:
- A request is accepted at a rising edge when if_en=1 and if_done=0.
- if_pc is captured into req_pc; if_pc is ignored afterwards until the request completes.
- Hit (valid && tag match): next cycle if_done=1, if_data=word[offset]; stay IDLE. Hit latency is 1 cycle; maximum throughput is one hit per 2 cycles.
- Miss: clear valid[index], mc_en=1, mc_pc=line base, counter=0, go REFILL.

REFILL:
- Each mc_done: write mc_data to word[counter], counter+1, mc_pc+4.
- After the last word: mc_en=0, write tag, valid[index]=1, go RESPOND.
- mc_done is ignored whenever mc_en=0.

RESPOND:
- Next edge: if_done=1 with the requested word, go IDLE.

if_done is registered and high for exactly one cycle.

Boundary conditions:
- rollback (any state): mc_en=0 and if_done=0 at the next edge, state IDLE, counter 0. The partially refilled line stays invalid; the memory controller discards its in-flight word. Rollback takes priority over a simultaneous mc_done or hit.
- if_en drops mid-refill without rollback: the refill completes and the line is installed, but no if_done is issued.
- rdy=0: no state, array or output register changes; mc_done/if_en are not sampled.
- Reset mid-refill: everything returns to reset values and all lines are invalid.
- Tag wrap: the counter wraps within the line only; mc_pc never crosses the line boundary.

Optional Feature:
ICACHE_EARLY_RESTART_EN
- Defined:
  - Refill starts at the requested word (critical word first) and wraps modulo LINE_WORDS within the line.
  - if_done pulses the cycle after the critical word's mc_done, with that word.
  - The refill continues to line completion.
  - A new if_en accepted during the remaining refill stalls until the line is installed, then is looked up normally.
  - Rollback during the tail of the refill also aborts it, and the line stays invalid.
- Undefined: refill starts at word 0 and if_done waits for RESPOND, as above.

Decomposition:
Shared package (macros file):
- ICACHE index/offset/tag width constants derived from the parameters.
- State encodings IC_IDLE/IC_REFILL/IC_RESPOND.
- Word width via the existing DATA/ADDR width macros.

Sub-module icache_array:
- valid/tag/data storage.
- One combinational read port (index → valid, tag, line words).
- One synchronous word-write port plus a tag/valid install strobe.
- Invalidate-all on rst.

Test Plan:
1. Cold miss: if_en, if_pc=0x0 → mc_pc 0x0,0x4,0x8,0xC each held to mc_done (data 0x11,0x22,0x33,0x44); if_done 2 cycles after the 4th mc_done, if_data=0x11. Then if_pc=0x8 → if_done 1 cycle later, if_data=0x33, mc_en stays 0.
2. Conflict eviction (LINES=64, LINE_WORDS=4): fill 0x000, then request 0x400 → refill of 0x400–0x40C; re-request 0x000 → miss and refill again.
3. Rollback after 2nd mc_done of a refill at 0x40 → mc_en=0 next cycle, no if_done; re-request 0x44 → full 4-word refill from 0x40.
4. rdy held low 5 cycles during REFILL with mc_done pulses masked → mc_pc, counter and outputs unchanged; resumes correctly when rdy returns high.
5. if_en dropped mid-refill → line still installed, no if_done; next request to the same line hits in 1 cycle.
6. With ICACHE_EARLY_RESTART_EN: miss at 0x8 → mc_pc order 0x8,0xC,0x0,0x4; if_done 1 cycle after the first mc_done; request 0xC during the tail stalls until the install, then hits.
